// File: rtl/keypad_pkg.sv
// Shared constants, scanner state encoding and key-code mapping for the
// 5x4 keypad scanner.
package keypad_pkg;

    localparam int NUM_ROWS = 5;
    localparam int NUM_COLS = 4;
    localparam int KEY_W    = 5;
    localparam int ROW_W    = 3;
    localparam int COL_W    = 2;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } kbd_state_e;

    function automatic logic [KEY_W-1:0] key_code_of(input logic [ROW_W-1:0] row,
                                                     input logic [COL_W-1:0] col);
        return KEY_W'(row) * KEY_W'(NUM_COLS) + KEY_W'(col);
    endfunction

    // Scanning from the top down lets the lowest-index low column win.
    function automatic logic [COL_W-1:0] first_low_col(input logic [NUM_COLS-1:0] cols);
        logic [COL_W-1:0] idx;
        idx = '0;
        for (int i = NUM_COLS - 1; i >= 0; i--) begin
            if (!cols[i]) idx = COL_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/kbd_tick_gen.sv
// Row-dwell counter: counts 0..DIV-1 and raises tick for one cycle at DIV-1.
module kbd_tick_gen #(
    parameter int DIV = 50000
) (
    input  logic clk_100mhz,
    input  logic rst,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    // NOTE: clocked state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/keypad_scan_fifo.sv
// Keypad matrix scanner with debounce and a one-entry key holding register
// popped by an active-low read strobe.
module keypad_scan_fifo
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int DEB_CNT  = 4
) (
    input  logic       clk_100mhz,
    input  logic       rst,
    input  logic [3:0] K_COL,
    input  logic       readn,
    output logic [4:0] K_ROW,
    output logic [4:0] key_code,
    output logic       RDY,
    output logic       overrun
);

    localparam int CNT_W = $clog2(DEB_CNT + 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CNT - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);

    logic [NUM_COLS-1:0] col_meta;
    logic [NUM_COLS-1:0] col_sync;
    logic                tick;

    kbd_state_e          state;
    logic [ROW_W-1:0]    row_idx;
    logic [ROW_W-1:0]    next_row;
    logic [ROW_W-1:0]    cand_row;
    logic [COL_W-1:0]    cand_col;
    logic [COL_W-1:0]    low_col;
    logic [CNT_W-1:0]    deb;
    logic [CNT_W-1:0]    rel;
    logic                any_low;
    logic                cand_low;
    logic                accept;

    kbd_tick_gen #(
        .DIV (SCAN_DIV)
    ) u_tick (
        .clk_100mhz (clk_100mhz),
        .rst        (rst),
        .tick       (tick)
    );

    // Synchroniser idles at all-ones, the released state of the pulled-up columns.
    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            col_meta <= '1;
            col_sync <= '1;
        end else begin
            col_meta <= K_COL;
            col_sync <= col_meta;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        any_low  = 1'b0;
        low_col  = '0;
        next_row = '0;
        any_low  = ~&col_sync;
        low_col  = first_low_col(col_sync);
        next_row = (row_idx == ROW_LAST) ? '0 : row_idx + 1'b1;
    end

    assign cand_low = ~col_sync[cand_col];
    assign accept   = tick && (state == DEBOUNCE) && cand_low && (deb == DEB_LAST);
    assign K_ROW    = ~(5'b00001 << row_idx);

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            state    <= SCAN;
            row_idx  <= '0;
            cand_row <= '0;
            cand_col <= '0;
            deb      <= '0;
            rel      <= '0;
        end else if (tick) begin
            case (state)
                SCAN: begin
                    if (any_low) begin
                        cand_col <= low_col;
                        cand_row <= row_idx;
                        deb      <= CNT_W'(1);
                        state    <= DEBOUNCE;
                    end else begin
                        row_idx <= next_row;
                    end
                end
                DEBOUNCE: begin
                    if (!cand_low) begin
                        deb     <= '0;
                        row_idx <= next_row;
                        state   <= SCAN;
                    end else if (deb == DEB_LAST) begin
                        deb   <= '0;
                        rel   <= '0;
                        state <= HELD;
                    end else begin
                        deb <= deb + 1'b1;
                    end
                end
                HELD: begin
                    // Row stays frozen until the candidate column reads released DEB_CNT times running.
                    if (cand_low) begin
                        rel <= '0;
                    end else if (rel == DEB_LAST) begin
                        rel     <= '0;
                        row_idx <= next_row;
                        state   <= SCAN;
                    end else begin
                        rel <= rel + 1'b1;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

    // A pop in the same cycle as an accept frees the slot, so the new key is loaded.
    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            key_code <= '0;
            RDY      <= 1'b0;
            overrun  <= 1'b0;
        end else if (accept) begin
            if (!RDY || !readn) begin
                key_code <= key_code_of(cand_row, cand_col);
                RDY      <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (!readn && RDY) begin
            RDY <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Directed bench for keypad_scan_fifo with a matrix model and a key-code scoreboard.
module tb_keypad_scan_fifo;

    logic       clk_100mhz = 1'b0;
    logic       rst;
    logic [3:0] K_COL;
    logic       readn;
    logic [4:0] K_ROW;
    logic [4:0] key_code;
    logic       RDY;
    logic       overrun;

    logic       pressed;
    int         prow;
    int         pcol;

    int         vec_cnt  = 0;
    int         miss_cnt = 0;
    logic [4:0] exp_q[$];

    keypad_scan_fifo #(
        .SCAN_DIV (4),
        .DEB_CNT  (3)
    ) dut (
        .clk_100mhz (clk_100mhz),
        .rst        (rst),
        .K_COL      (K_COL),
        .readn      (readn),
        .K_ROW      (K_ROW),
        .key_code   (key_code),
        .RDY        (RDY),
        .overrun    (overrun)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    // Pressed key shorts its column low only while its row is driven low.
    always_comb begin
        K_COL = 4'hF;
        if (pressed && !K_ROW[prow]) K_COL[pcol] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miss_cnt++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("%s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input int r, input int c);
        prow    = r;
        pcol    = c;
        pressed = 1'b1;
    endtask

    task automatic wait_rdy(input int budget, output int waited);
        waited = 0;
        while (waited < budget && RDY !== 1'b1) begin
            @(negedge clk_100mhz);
            waited++;
        end
    endtask

    task automatic wait_row_leave(input logic [4:0] from, input int budget);
        for (int i = 0; i < budget && K_ROW === from; i++) @(negedge clk_100mhz);
    endtask

    task automatic wait_row_reach(input logic [4:0] target, input int budget);
        for (int i = 0; i < budget && K_ROW !== target; i++) @(negedge clk_100mhz);
    endtask

    // Waits for RDY, then compares key_code against the oldest queued expectation.
    task automatic expect_key(input string tag, input int budget);
        int         waited;
        logic [4:0] exp;
        wait_rdy(budget, waited);
        check({tag, "_rdy"}, RDY, 1'b1);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 5'h1F;
        check({tag, "_code"}, key_code, exp);
    endtask

    logic [4:0] rot_exp[5];
    int         waited;

    initial begin
        rot_exp[0] = 5'b11101;
        rot_exp[1] = 5'b11011;
        rot_exp[2] = 5'b10111;
        rot_exp[3] = 5'b01111;
        rot_exp[4] = 5'b11110;

        rst     = 1'b1;
        readn   = 1'b1;
        pressed = 1'b0;
        prow    = 0;
        pcol    = 0;

        // Reset and idle rotation.
        repeat (3) @(negedge clk_100mhz);
        check("rst_krow", K_ROW, 5'b11110);
        check("rst_rdy", RDY, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        check("rst_code", key_code, 5'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk_100mhz);
        check("dwell_hold", K_ROW, 5'b11110);
        @(negedge clk_100mhz);
        check("rot_1", K_ROW, rot_exp[0]);
        for (int i = 1; i < 5; i++) begin
            repeat (4) @(negedge clk_100mhz);
            check($sformatf("rot_%0d", i + 1), K_ROW, rot_exp[i]);
        end

        // Clean press of row 2, col 1; RDY rises exactly 20 cycles after pressing at row 0.
        press(2, 1);
        exp_q.push_back(5'd9);
        wait_rdy(100, waited);
        check("clean_latency", waited, 20);
        check("clean_rdy", RDY, 1'b1);
        check("clean_code", key_code, exp_q.pop_front());
        check("clean_frozen", K_ROW, 5'b11011);
        readn = 1'b0;
        @(negedge clk_100mhz);
        readn = 1'b1;
        check("pop_rdy", RDY, 1'b0);
        check("pop_code_keep", key_code, 5'd9);
        pressed = 1'b0;
        repeat (8) @(negedge clk_100mhz);
        check("release_hold", K_ROW, 5'b11011);
        wait_row_leave(5'b11011, 40);
        check("release_adv", K_ROW, 5'b10111);

        // Bounce: row 3, col 0 seen on a single tick only.
        press(3, 0);
        repeat (4) @(negedge clk_100mhz);
        pressed = 1'b0;
        check("bounce_frozen", K_ROW, 5'b10111);
        repeat (4) @(negedge clk_100mhz);
        check("bounce_resume", K_ROW, 5'b01111);
        check("bounce_rdy", RDY, 1'b0);

        // Overrun: hold key 9 unread, then a second key is dropped.
        press(2, 1);
        exp_q.push_back(5'd9);
        expect_key("ovr_first", 100);
        pressed = 1'b0;
        wait_row_leave(5'b11011, 60);
        check("ovr_release", K_ROW, 5'b10111);
        press(0, 3);
        for (int i = 0; i < 100 && overrun !== 1'b1; i++) @(negedge clk_100mhz);
        check("ovr_flag", overrun, 1'b1);
        check("ovr_code", key_code, 5'd9);
        check("ovr_rdy", RDY, 1'b1);
        pressed = 1'b0;
        wait_row_leave(5'b11110, 60);
        check("ovr_release2", K_ROW, 5'b11101);
        readn = 1'b0;
        repeat (3) @(negedge clk_100mhz);
        readn = 1'b1;
        check("long_pop_rdy", RDY, 1'b0);
        check("long_pop_code", key_code, 5'd9);
        check("ovr_sticky", overrun, 1'b1);

        // Simultaneous pop and accept of row 4, col 2.
        rst = 1'b1;
        @(negedge clk_100mhz);
        rst = 1'b0;
        check("rst2_ovr", overrun, 1'b0);
        press(1, 0);
        exp_q.push_back(5'd4);
        expect_key("pre_sim", 100);
        pressed = 1'b0;
        wait_row_leave(5'b11101, 60);
        check("pre_sim_release", K_ROW, 5'b11011);
        press(4, 2);
        exp_q.push_back(5'd18);
        wait_row_reach(5'b01111, 60);
        repeat (11) @(negedge clk_100mhz);
        check("sim_pre_rdy", RDY, 1'b1);
        check("sim_pre_code", key_code, 5'd4);
        readn = 1'b0;
        @(negedge clk_100mhz);
        readn = 1'b1;
        check("sim_rdy", RDY, 1'b1);
        check("sim_code", key_code, exp_q.size() > 0 ? exp_q.pop_front() : 5'h1F);
        check("sim_ovr", overrun, 1'b0);

        // Reset in the middle of a debounce.
        pressed = 1'b0;
        wait_row_leave(5'b01111, 60);
        check("pre_mid_row", K_ROW, 5'b11110);
        press(0, 0);
        repeat (6) @(negedge clk_100mhz);
        rst = 1'b1;
        #1;
        check("mid_rst_krow", K_ROW, 5'b11110);
        check("mid_rst_rdy", RDY, 1'b0);
        check("mid_rst_code", key_code, 5'd0);
        check("mid_rst_ovr", overrun, 1'b0);
        pressed = 1'b0;
        repeat (2) @(negedge clk_100mhz);
        rst = 1'b0;
        repeat (60) @(negedge clk_100mhz);
        check("post_rst_rdy", RDY, 1'b0);
        check("post_rst_code", key_code, 5'd0);
        check("sb_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
